calc_op_seq: RTL

- Sequencer that executes one RPN operator against the calculator's operand stack.
- Accepts a 3-bit opcode from the front-panel FSM and drives the stack's push/pop/replace/in_num inputs over several cycles.
- Performs unsigned 32-bit arithmetic, including a 32-cycle iterative divider.
- Reports completion or an error code, and never leaves the stack half-modified on an error it can detect up front.

---
 rtl/calc_op_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_op_seq.sv
// RPN operator sequencer: runs one opcode against the operand stack through
// registered single-cycle push/pop/replace requests, with a restoring divider.
module calc_op_seq #(
    parameter int SIZE_W = 10,
    parameter int DEPTH  = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    output logic              cmd_ready,
    output logic              done,
    output logic [1:0]        err,
    input  logic [31:0]       stk_top,
    input  logic [SIZE_W-1:0] stk_size,
    output logic              stk_push,
    output logic              stk_pop,
    output logic              stk_replace,
    output logic [31:0]       stk_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_POPB, S_LOADA, S_EXEC, S_DIVIDE, S_WR, S_PUSHA, S_FIN
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_MOD  = 3'd4;
    localparam logic [2:0] OP_POP  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_DUP  = 3'd7;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_DIV0  = 2'b11;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        push_q, push_d, pop_q, pop_d, replace_q, replace_d;
    logic [31:0] stk_in_q, stk_in_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;

    logic        need_two, need_one;
    logic [32:0] rem_shift, rem_sub;
    logic [31:0] quo_step, rem_step;

    // One restoring-division step: bit 32 of the trial difference flags a borrow.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        rem_sub   = rem_shift - {1'b0, b_q};
        if (!rem_sub[32]) begin
            rem_step = rem_sub[31:0];
            quo_step = {quo_q[30:0], 1'b1};
        end else begin
            rem_step = rem_shift[31:0];
            quo_step = {quo_q[30:0], 1'b0};
        end
    end

    assign need_two = (cmd_op <= OP_MOD) || (cmd_op == OP_SWAP);
    assign need_one = (cmd_op == OP_POP) || (cmd_op == OP_DUP);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        push_d    = 1'b0;
        pop_d     = 1'b0;
        replace_d = 1'b0;
        stk_in_d  = stk_in_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    // Rejections are decided before any stack request is issued.
                    if ((need_two && stk_size < SIZE_W'(2)) ||
                        (need_one && stk_size == '0)) begin
                        done_d = 1'b1;
                        err_d  = ERR_UNDER;
                    end else if (cmd_op == OP_DUP && stk_size == SIZE_W'(DEPTH)) begin
                        done_d = 1'b1;
                        err_d  = ERR_OVER;
                    end else if ((cmd_op == OP_DIV || cmd_op == OP_MOD) && stk_top == 32'd0) begin
                        done_d = 1'b1;
                        err_d  = ERR_DIV0;
                    end else begin
                        op_d = cmd_op;
                        case (cmd_op)
                            OP_POP: begin
                                pop_d   = 1'b1;
                                state_d = S_FIN;
                            end
                            OP_DUP: begin
                                stk_in_d = stk_top;
                                push_d   = 1'b1;
                                state_d  = S_FIN;
                            end
                            default: begin
                                b_d     = stk_top;
                                pop_d   = 1'b1;
                                state_d = S_POPB;
                            end
                        endcase
                    end
                end
            end
            S_POPB: state_d = S_LOADA;
            S_LOADA: begin
                a_d     = stk_top;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d   = S_WR;
                replace_d = 1'b1;
                case (op_q)
                    OP_ADD:  stk_in_d = a_q + b_q;
                    OP_SUB:  stk_in_d = a_q - b_q;
                    OP_MUL:  stk_in_d = a_q * b_q;
                    OP_SWAP: stk_in_d = b_q;
                    default: begin
                        replace_d = 1'b0;
                        rem_d     = 32'd0;
                        quo_d     = a_q;
                        cnt_d     = 5'd0;
                        state_d   = S_DIVIDE;
                    end
                endcase
            end
            S_DIVIDE: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    stk_in_d  = (op_q == OP_DIV) ? quo_step : rem_step;
                    replace_d = 1'b1;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                if (op_q == OP_SWAP) begin
                    stk_in_d = a_q;
                    push_d   = 1'b1;
                    state_d  = S_PUSHA;
                end else begin
                    done_d  = 1'b1;
                    err_d   = ERR_OK;
                    state_d = S_IDLE;
                end
            end
            S_PUSHA, S_FIN: begin
                done_d  = 1'b1;
                err_d   = ERR_OK;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            replace_q <= 1'b0;
            stk_in_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            push_q    <= push_d;
            pop_q     <= pop_d;
            replace_q <= replace_d;
            stk_in_q  <= stk_in_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign stk_push    = push_q;
    assign stk_pop     = pop_q;
    assign stk_replace = replace_q;
    assign stk_in      = stk_in_q;

endmodule
